// File: rtl/sd_spi_if.sv
// sd_spi_if: bundle of the byte-transfer handshake and SPI pins of sd_spi_master.
//   master modport: the SD host side (issues requests, drives miso from the card model).
//   slave  modport: the sd_spi_master block itself.
// Signals:
//   div      SCK half-period minus one      start    request a byte transfer
//   tx_data  byte to send, MSB first        cs_wr    chip-select write strobe
//   cs_val   new chip-select level          rx_data  received byte
//   busy     transfer in progress           done     one-cycle completion pulse
//   sck/mosi/miso/cs_n  SPI pins            act      activity indication
interface sd_spi_if #(
    parameter int unsigned DIV_W = 8
);
    logic [DIV_W-1:0] div;
    logic             start;
    logic [7:0]       tx_data;
    logic             cs_wr;
    logic             cs_val;
    logic [7:0]       rx_data;
    logic             busy;
    logic             done;
    logic             sck;
    logic             mosi;
    logic             miso;
    logic             cs_n;
    logic             act;

    modport master (
        output div, start, tx_data, cs_wr, cs_val, miso,
        input  rx_data, busy, done, sck, mosi, cs_n, act
    );

    modport slave (
        input  div, start, tx_data, cs_wr, cs_val, miso,
        output rx_data, busy, done, sck, mosi, cs_n, act
    );
endinterface

// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-wide SPI mode-0 initiator for an SD card.
// Each transfer is full duplex: tx_data goes out MSB first on mosi while miso is shifted in.
// SCK half-period is div+1 clk cycles; div and tx_data are latched when start is accepted.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous reset, active-high
//   bus    sd_spi_if.slave (div, start, tx_data, cs_wr, cs_val, rx_data, busy, done,
//          sck, mosi, miso, cs_n, act)
// Optional feature: define SD_SPI_ACT_EN to build the activity-stretch counter behind act;
// otherwise act is tied low.
module sd_spi_master #(
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned ACT_TICKS = 1000000
) (
    input logic    clk,
    input logic    reset,
    sd_spi_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StFin} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_q, rx_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             busy;
    logic             phase_end;

    assign phase_end = (phase_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start) state_d = StLow;
            StLow:  if (phase_end) state_d = StHigh;
            StHigh: if (phase_end) state_d = (bit_q == 3'd0) ? StFin : StLow;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath / output next-values
    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;

        if (bus.cs_wr && !busy) cs_n_d = bus.cs_val;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    div_d   = bus.div;
                    phase_d = bus.div;
                    shift_d = bus.tx_data;
                    mosi_d  = bus.tx_data[7];
                    bit_d   = 3'd7;
                    sck_d   = 1'b0;
                end
            end
            StLow: begin
                if (phase_end) begin
                    // Rising SCK: sample miso; the same register shifts tx out of bit 7.
                    sck_d   = 1'b1;
                    shift_d = {shift_q[6:0], bus.miso};
                    phase_d = div_q;
                end else begin
                    phase_d = phase_q - DIV_W'(1);
                end
            end
            StHigh: begin
                if (phase_end) begin
                    sck_d   = 1'b0;
                    phase_d = div_q;
                    if (bit_q != 3'd0) begin
                        bit_d  = bit_q - 3'd1;
                        mosi_d = shift_q[7];
                    end else begin
                        // Load rx on entry to FIN so it is valid in the done cycle.
                        rx_d   = shift_q;
                        mosi_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q - DIV_W'(1);
                end
            end
            StFin: begin
                mosi_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            phase_q <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'hFF;
            rx_q    <= 8'hFF;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            cs_n_q  <= 1'b1;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == StLow) || (state_q == StHigh);
    end

    assign bus.busy    = busy;
    assign bus.done    = (state_q == StFin);
    assign bus.rx_data = rx_q;
    assign bus.sck     = sck_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;

`ifdef SD_SPI_ACT_EN
    localparam int unsigned ActW = $clog2(ACT_TICKS + 1);

    logic [ActW-1:0] act_q, act_d;
    logic            mosi_prev_q;
    logic            miso_prev_q;

    // Any pin edge reloads the stretch counter; otherwise count down to 0 and hold.
    always_comb begin
        act_d = act_q;
        if ((mosi_q != mosi_prev_q) || (bus.miso != miso_prev_q)) begin
            act_d = ActW'(ACT_TICKS - 1);
        end else if (act_q != '0) begin
            act_d = act_q - ActW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q       <= '0;
            mosi_prev_q <= 1'b1;
            miso_prev_q <= 1'b1;
        end else begin
            act_q       <= act_d;
            mosi_prev_q <= mosi_q;
            miso_prev_q <= bus.miso;
        end
    end

    assign bus.act = (act_q != '0);
`else
    assign bus.act = 1'b0;
`endif

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: directed self-checking bench for sd_spi_master (default build, act tied 0).
module tb_sd_spi_master;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sd_spi_if #(.DIV_W(8)) sif ();

    sd_spi_master #(
        .DIV_W     (8),
        .ACT_TICKS (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    logic loop_en;
    logic miso_drv;
    assign sif.miso = loop_en ? sif.mosi : miso_drv;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int sck_rises = 0;
    int hi_run    = 0;
    int hi_bad    = 0;
    int exp_half  = 1;
    logic       sck_prev  = 1'b0;
    logic [7:0] mosi_bits = 8'h00;

    // Passive monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (sif.done === 1'b1) done_cnt++;
        if (sif.sck === 1'b1 && sck_prev === 1'b0) begin
            sck_rises++;
            mosi_bits = {mosi_bits[6:0], sif.mosi};
        end
        if (sif.sck === 1'b1) begin
            hi_run++;
        end else begin
            if (sck_prev === 1'b1 && hi_run != exp_half) hi_bad++;
            hi_run = 0;
        end
        sck_prev = sif.sck;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer; intr>0 injects an ignored start+cs_wr in that cycle.
    task automatic xfer(input logic [7:0] d, input logic [7:0] t, input bit with_cs,
                        input int intr, input logic [7:0] exp_rx, input string tag);
        int cyc;
        int d0;
        exp_half  = int'(d) + 1;
        sck_rises = 0;
        hi_bad    = 0;
        d0        = done_cnt;
        sif.div     = d;
        sif.tx_data = t;
        sif.start   = 1'b1;
        if (with_cs) begin
            sif.cs_wr  = 1'b1;
            sif.cs_val = 1'b0;
        end
        tick();
        sif.start   = 1'b0;
        sif.cs_wr   = 1'b0;
        sif.div     = 8'h00;
        sif.tx_data = 8'h00;
        cyc = 1;
        check({tag, ".busy_c1"}, 32'(sif.busy), 32'd1);
        check({tag, ".mosi_c1"}, 32'(sif.mosi), 32'(t[7]));
        check({tag, ".sck_c1"}, 32'(sif.sck), 32'd0);
        if (with_cs) check({tag, ".cs_n_c1"}, 32'(sif.cs_n), 32'd0);
        while (sif.done !== 1'b1 && cyc < 2000) begin
            if (cyc == intr) begin
                sif.start   = 1'b1;
                sif.tx_data = 8'hFF;
                sif.cs_wr   = 1'b1;
                sif.cs_val  = 1'b1;
            end
            tick();
            cyc++;
            sif.start = 1'b0;
            sif.cs_wr = 1'b0;
        end
        check({tag, ".done_cycle"}, 32'(cyc), 32'(1 + 16 * (int'(d) + 1)));
        check({tag, ".rx_data"}, 32'(sif.rx_data), 32'(exp_rx));
        check({tag, ".busy_done"}, 32'(sif.busy), 32'd0);
        check({tag, ".mosi_done"}, 32'(sif.mosi), 32'd1);
        check({tag, ".sck_done"}, 32'(sif.sck), 32'd0);
        tick();
        check({tag, ".done_after"}, 32'(sif.done), 32'd0);
        check({tag, ".done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, ".sck_rises"}, 32'(sck_rises), 32'd8);
        check({tag, ".sck_high_len"}, 32'(hi_bad), 32'd0);
        check({tag, ".mosi_bits"}, 32'(mosi_bits), 32'(t));
    endtask

    initial begin
        int d0;
        reset       = 1'b1;
        sif.start   = 1'b0;
        sif.div     = 8'h00;
        sif.tx_data = 8'h00;
        sif.cs_wr   = 1'b0;
        sif.cs_val  = 1'b1;
        loop_en     = 1'b1;
        miso_drv    = 1'b1;
        repeat (3) tick();

        check("rst.sck", 32'(sif.sck), 32'd0);
        check("rst.mosi", 32'(sif.mosi), 32'd1);
        check("rst.cs_n", 32'(sif.cs_n), 32'd1);
        check("rst.busy", 32'(sif.busy), 32'd0);
        check("rst.done", 32'(sif.done), 32'd0);
        check("rst.rx_data", 32'(sif.rx_data), 32'hFF);
        check("rst.act", 32'(sif.act), 32'd0);
        reset = 1'b0;
        tick();

        // Select the card while idle
        sif.cs_wr  = 1'b1;
        sif.cs_val = 1'b0;
        tick();
        sif.cs_wr = 1'b0;
        check("idle_cs_wr.cs_n", 32'(sif.cs_n), 32'd0);

        // Loopback byte at div=0 with an ignored start/cs_wr in cycle 5
        xfer(8'd0, 8'hA5, 1'b0, 5, 8'hA5, "c1");
        check("c1.cs_n_kept", 32'(sif.cs_n), 32'd0);
        check("c1.act", 32'(sif.act), 32'd0);

        // div=3, miso tied low; div input is zeroed while busy and must be ignored
        loop_en  = 1'b0;
        miso_drv = 1'b0;
        xfer(8'd3, 8'h3C, 1'b0, -1, 8'h00, "c2");

        // Deselect, then cs_wr together with start
        sif.cs_wr  = 1'b1;
        sif.cs_val = 1'b1;
        tick();
        sif.cs_wr = 1'b0;
        check("deselect.cs_n", 32'(sif.cs_n), 32'd1);
        loop_en = 1'b1;
        xfer(8'd0, 8'h40, 1'b1, -1, 8'h40, "c4");
        check("c4.cs_n_after", 32'(sif.cs_n), 32'd0);

        // Back-to-back start in the cycle after done's follow-up, div=1
        xfer(8'd1, 8'h96, 1'b0, -1, 8'h96, "b2b");

        // Reset in cycle 9 of a div=0 transfer
        sif.div     = 8'h00;
        sif.tx_data = 8'hC3;
        sif.start   = 1'b1;
        tick();
        sif.start = 1'b0;
        repeat (8) tick();
        check("c5.busy_before", 32'(sif.busy), 32'd1);
        d0    = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("c5.sck", 32'(sif.sck), 32'd0);
        check("c5.mosi", 32'(sif.mosi), 32'd1);
        check("c5.cs_n", 32'(sif.cs_n), 32'd1);
        check("c5.busy", 32'(sif.busy), 32'd0);
        check("c5.rx_data", 32'(sif.rx_data), 32'hFF);
        repeat (40) tick();
        check("c5.no_done", 32'(done_cnt - d0), 32'd0);
        check("c5.busy_later", 32'(sif.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
